// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer and its condition evaluator.
//
// Contents:
//   tx_cmd_e   - TX command codes driven on tx_command
//   CC_*       - condition-code bit positions and the cc[2:0] selector encodings
package stage_sequencer_pkg;

  typedef enum logic [1:0] {
    TX_NONE     = 2'd0,
    TX_READ_16  = 2'd1,
    TX_WRITE_16 = 2'd2,
    TX_WRITE_8  = 2'd3
  } tx_cmd_e;

  // cc[3] inverts the selected condition, cc[2:0] selects it
  localparam int CC_INV_BIT = 3;
  localparam int CC_SEL_MSB = 2;
  localparam int CC_SEL_LSB = 0;

  typedef enum logic [2:0] {
    CC_ALWAYS     = 3'b000,
    CC_Z          = 3'b001,
    CC_S          = 3'b010,
    CC_ALWAYS_ALT = 3'b011,
    CC_C          = 3'b100,
    CC_V          = 3'b101,
    CC_C_NZ       = 3'b110,
    CC_V_NZ       = 3'b111
  } cc_sel_e;

endpackage

// File: rtl/stage_sequencer_cc_eval.sv
// Purely combinational condition-code evaluation.
//
// Ports:
//   cc                               in  [3:0] condition code (bit 3 inverts)
//   flag_c, flag_v, flag_s, flag_z   in        ALU flags
//   cc_ok                            out       condition satisfied
module stage_sequencer_cc_eval
  import stage_sequencer_pkg::*;
(
  input  logic [3:0] cc,
  input  logic       flag_c,
  input  logic       flag_v,
  input  logic       flag_s,
  input  logic       flag_z,
  output logic       cc_ok
);

  logic raw;

  always_comb begin
    raw = 1'b1;
    case (cc[CC_SEL_MSB:CC_SEL_LSB])
      CC_ALWAYS:     raw = 1'b1;
      CC_Z:          raw = flag_z;
      CC_S:          raw = flag_s;
      CC_ALWAYS_ALT: raw = 1'b1;
      CC_C:          raw = flag_c;
      CC_V:          raw = flag_v;
      CC_C_NZ:       raw = flag_c && !flag_z;
      CC_V_NZ:       raw = flag_v && !flag_z;
      default:       raw = 1'b1;
    endcase
  end

  assign cc_ok = raw ^ cc[CC_INV_BIT];

endmodule

// File: rtl/stage_sequencer.sv
// Instruction sequencer for the 2-bit-serial CPU. Steps an instruction
// through 1..MAX_STAGES programmable stages, issues a TX command per stage,
// gates the ALU on TX/RX/prefetch readiness and tracks reads in flight.
//
// Build option: SEQ_PIPELINED_READ_EN allows up to MAX_OUTSTANDING reads in
// flight; without it a read waits until no read is outstanding.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_valid / inst_done        instruction handshake (done is a 1-cycle pulse)
//   num_stages                    stage count (0 -> 1, above MAX_STAGES clamped)
//   stage_read/write/wait_data/pc per-stage behaviour masks
//   wide, use_cc, cc, flag_*      write width, conditional execution inputs
//   stage                         current stage index
//   alu_en / op_done              ALU handshake
//   prefetch_idle/block_prefetch  prefetcher interlock
//   reserve_tx, tx_command_*      TX command interface
//   tx_data_next                  TX requests next payload symbol
//   rx_started/data_valid/done    RX reply progress
//   outstanding, protocol_error   reads in flight, sticky unexpected rx_done
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MAX_STAGES      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TX_CMD_BITS     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 inst_valid,
  output logic                                 inst_done,
  input  logic [$clog2(MAX_STAGES):0]          num_stages,
  input  logic [MAX_STAGES-1:0]                stage_read,
  input  logic [MAX_STAGES-1:0]                stage_write,
  input  logic [MAX_STAGES-1:0]                stage_wait_data,
  input  logic [MAX_STAGES-1:0]                stage_pc,
  input  logic                                 wide,
  input  logic                                 use_cc,
  input  logic [3:0]                           cc,
  input  logic                                 flag_c,
  input  logic                                 flag_v,
  input  logic                                 flag_s,
  input  logic                                 flag_z,
  output logic [$clog2(MAX_STAGES)-1:0]        stage,
  output logic                                 alu_en,
  input  logic                                 op_done,
  input  logic                                 prefetch_idle,
  output logic                                 block_prefetch,
  output logic                                 reserve_tx,
  output logic                                 tx_command_valid,
  output logic [TX_CMD_BITS-1:0]               tx_command,
  input  logic                                 tx_command_started,
  input  logic                                 tx_data_next,
  input  logic                                 rx_started,
  input  logic                                 rx_data_valid,
  input  logic                                 rx_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 protocol_error
);

  localparam int SW  = $clog2(MAX_STAGES);
  localparam int NSW = SW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [NSW-1:0] clamp_stages(input logic [NSW-1:0] n);
    if (n == '0)
      return NSW'(1);
    else if (n > NSW'(MAX_STAGES))
      return NSW'(MAX_STAGES);
    else
      return n;
  endfunction

  // Issue and completion in the same cycle cancel; the count never wraps.
  function automatic logic [OW-1:0] sat_count(input logic [OW-1:0] cnt,
                                              input logic inc, input logic dec);
    if (inc && !dec && cnt != OW'(MAX_OUTSTANDING))
      return cnt + OW'(1);
    else if (dec && !inc && cnt != '0)
      return cnt - OW'(1);
    else
      return cnt;
  endfunction

  logic [SW-1:0]         stage_q;
  logic                  command_active;
  logic [OW-1:0]         out_q;
  logic                  perr_q;
  logic                  cc_ok, run, skip, execute;
  logic [NSW-1:0]        ns_eff;
  logic [SW-1:0]         last_stage;
  logic [MAX_STAGES-1:0] stage_mask;
  logic                  cur_read, cur_write, cur_wait, cur_pc;
  logic                  send, pc_hold, read_slots_full, cmd_wait, read_started;
  logic [1:0]            cmd_code;

  stage_sequencer_cc_eval u_cc_eval (
    .cc     (cc),
    .flag_c (flag_c),
    .flag_v (flag_v),
    .flag_s (flag_s),
    .flag_z (flag_z),
    .cc_ok  (cc_ok)
  );

  // Reset gates every combinational output so nothing leaks while held.
  assign run     = inst_valid && !reset;
  assign skip    = run && use_cc && !cc_ok;
  assign execute = run && !skip;

  assign ns_eff     = clamp_stages(num_stages);
  assign last_stage = SW'(ns_eff - NSW'(1));

  always_comb begin
    stage_mask = '0;
    for (int i = 0; i < MAX_STAGES; i++)
      stage_mask[i] = (NSW'(i) < ns_eff);
  end

  assign cur_read  = stage_read[stage_q];
  assign cur_write = stage_write[stage_q];
  assign cur_wait  = stage_wait_data[stage_q];
  assign cur_pc    = stage_pc[stage_q];
  assign send      = cur_read || cur_write;
  assign pc_hold   = cur_pc && !prefetch_idle;

`ifdef SEQ_PIPELINED_READ_EN
  assign read_slots_full = (out_q == OW'(MAX_OUTSTANDING));
`else
  assign read_slots_full = (out_q != '0);
`endif

  assign cmd_wait = pc_hold || (cur_wait && !rx_started) || (cur_read && read_slots_full);

  assign cmd_code         = cur_read ? TX_READ_16 : (wide ? TX_WRITE_16 : TX_WRITE_8);
  assign tx_command       = (execute && send) ? TX_CMD_BITS'(cmd_code) : '0;
  assign tx_command_valid = execute && send && !command_active && !cmd_wait;

  // The ALU may only move a payload once TX has started and asks for data.
  assign alu_en = execute && !pc_hold && !(cur_wait && !rx_data_valid)
                  && !(send && !(command_active && tx_data_next));

  assign block_prefetch = execute && cur_pc;
  assign reserve_tx     = execute && |(stage_write & stage_mask);
  assign inst_done      = skip || (execute && op_done && (stage_q == last_stage));
  assign read_started   = execute && cur_read && tx_command_started;

  assign stage          = stage_q;
  assign outstanding    = out_q;
  assign protocol_error = perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q        <= '0;
      command_active <= 1'b0;
      out_q          <= '0;
      perr_q         <= 1'b0;
    end else begin
      if (execute && op_done)
        stage_q <= (stage_q == last_stage) ? '0 : stage_q + SW'(1);
      if (op_done)
        command_active <= 1'b0;
      else if (tx_command_started)
        command_active <= 1'b1;
      out_q <= sat_count(out_q, read_started, rx_done);
      if (rx_done && out_q == '0)
        perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  localparam int MAX_STAGES = 4;
  localparam int MAX_OUT    = 2;

  logic       clk, reset, inst_valid, inst_done;
  logic [2:0] num_stages;
  logic [3:0] stage_read, stage_write, stage_wait_data, stage_pc;
  logic       wide, use_cc;
  logic [3:0] cc;
  logic       flag_c, flag_v, flag_s, flag_z;
  logic [1:0] stage;
  logic       alu_en, op_done, prefetch_idle, block_prefetch, reserve_tx;
  logic       tx_command_valid;
  logic [1:0] tx_command;
  logic       tx_command_started, tx_data_next, rx_started, rx_data_valid, rx_done;
  logic [1:0] outstanding;
  logic       protocol_error;

  stage_sequencer #(.MAX_STAGES(MAX_STAGES), .MAX_OUTSTANDING(MAX_OUT), .TX_CMD_BITS(2)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_done(inst_done),
    .num_stages(num_stages), .stage_read(stage_read), .stage_write(stage_write),
    .stage_wait_data(stage_wait_data), .stage_pc(stage_pc), .wide(wide),
    .use_cc(use_cc), .cc(cc), .flag_c(flag_c), .flag_v(flag_v), .flag_s(flag_s),
    .flag_z(flag_z), .stage(stage), .alu_en(alu_en), .op_done(op_done),
    .prefetch_idle(prefetch_idle), .block_prefetch(block_prefetch),
    .reserve_tx(reserve_tx), .tx_command_valid(tx_command_valid),
    .tx_command(tx_command), .tx_command_started(tx_command_started),
    .tx_data_next(tx_data_next), .rx_started(rx_started),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level state plus the stated output rules.
  int m_stage = 0;
  int m_out   = 0;
  bit m_cmd   = 0;
  bit m_perr  = 0;

  typedef struct {
    bit done, alu, valid, blk, rsv, exe, rd;
    int cmd;
  } exp_t;

  function automatic bit cc_ok_f(input logic [3:0] c);
    bit r;
    case (c[2:0])
      3'd1:    r = flag_z;
      3'd2:    r = flag_s;
      3'd4:    r = flag_c;
      3'd5:    r = flag_v;
      3'd6:    r = flag_c && !flag_z;
      3'd7:    r = flag_v && !flag_z;
      default: r = 1'b1;
    endcase
    return r ^ c[3];
  endfunction

  function automatic int ns_eff_f();
    int n = int'(num_stages);
    if (n == 0) n = 1;
    if (n > MAX_STAGES) n = MAX_STAGES;
    return n;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   s, ns;
    bit   rd, wr, wd, pc, send, full, pch;
    e = '{default: 0};
    if (reset || !inst_valid) return e;
    if (use_cc && !cc_ok_f(cc)) begin
      e.done = 1;
      return e;
    end
    ns = ns_eff_f();
    s  = m_stage;
    rd = stage_read[s]; wr = stage_write[s]; wd = stage_wait_data[s]; pc = stage_pc[s];
    send = rd || wr;
    pch  = pc && !prefetch_idle;
`ifdef SEQ_PIPELINED_READ_EN
    full = (m_out >= MAX_OUT);
`else
    full = (m_out != 0);
`endif
    e.exe   = 1;
    e.rd    = rd;
    e.valid = send && !m_cmd && !(pch || (wd && !rx_started) || (rd && full));
    e.cmd   = rd ? 1 : (wide ? 2 : 3);
    e.alu   = !pch && !(wd && !rx_data_valid) && !(send && !(m_cmd && tx_data_next));
    e.blk   = pc;
    for (int i = 0; i < ns; i++) if (stage_write[i]) e.rsv = 1;
    e.done  = op_done && (s == ns - 1);
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_stage <= 0; m_cmd <= 0; m_out <= 0; m_perr <= 0;
    end else begin
      if (model().exe && op_done)
        m_stage <= (m_stage == ns_eff_f() - 1) ? 0 : m_stage + 1;
      if (op_done) m_cmd <= 0;
      else if (tx_command_started) m_cmd <= 1;
      if ((tx_command_started && model().exe && model().rd) && !rx_done)
        m_out <= m_out + 1;
      else if (!(tx_command_started && model().exe && model().rd) && rx_done && m_out > 0)
        m_out <= m_out - 1;
      if (rx_done && m_out == 0) m_perr <= 1;
    end
  end

  // Cycle compare: inputs are settled by negedge+3, the active edge is at +5.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      begin
        exp_t e;
        e = model();
        chk("cmp_inst_done", int'(inst_done), int'(e.done));
        chk("cmp_alu_en", int'(alu_en), int'(e.alu));
        chk("cmp_tx_valid", int'(tx_command_valid), int'(e.valid));
        chk("cmp_block_prefetch", int'(block_prefetch), int'(e.blk));
        chk("cmp_reserve_tx", int'(reserve_tx), int'(e.rsv));
        if (e.valid) chk("cmp_tx_command", int'(tx_command), e.cmd);
        if (!reset) begin
          chk("cmp_stage", int'(stage), m_stage);
          chk("cmp_outstanding", int'(outstanding), m_out);
          chk("cmp_protocol_error", int'(protocol_error), int'(m_perr));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    inst_valid = 0; num_stages = 3'd1;
    stage_read = '0; stage_write = '0; stage_wait_data = '0; stage_pc = '0;
    wide = 0; use_cc = 0; cc = '0; flag_c = 0; flag_v = 0; flag_s = 0; flag_z = 0;
    op_done = 0; prefetch_idle = 1; tx_command_started = 0; tx_data_next = 0;
    rx_started = 0; rx_data_valid = 0; rx_done = 0;
  endtask

  int n_inst = 0;
  bit need_new;

  initial begin
    reset = 1;
    idle_inputs();
    inst_valid = 1;
    repeat (2) @(posedge clk);

    // Reset holds every output low even with an instruction present.
    @(negedge clk); #1;
    chk("rst_inst_done", int'(inst_done), 0);
    chk("rst_alu_en", int'(alu_en), 0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_perr", int'(protocol_error), 0);
    reset = 0; inst_valid = 0;

    // Skipped conditional instruction, then the inverted condition executes.
    @(negedge clk);
    inst_valid = 1; use_cc = 1; cc = 4'b0001; flag_z = 0; num_stages = 3'd1; #1;
    chk("skip_inst_done", int'(inst_done), 1);
    chk("skip_tx_valid", int'(tx_command_valid), 0);
    chk("skip_alu_en", int'(alu_en), 0);
    @(negedge clk);
    cc = 4'b1001; #1;
    chk("ccinv_not_done", int'(inst_done), 0);
    chk("ccinv_alu_en", int'(alu_en), 1);
    op_done = 1; #1;
    chk("ccinv_done", int'(inst_done), 1);
    @(negedge clk); idle_inputs();

    // Read in stage 0, reply consumed in stage 1.
    @(negedge clk);
    inst_valid = 1; num_stages = 3'd2; stage_read = 4'b0001; stage_wait_data = 4'b0010; #1;
    chk("rd_tx_valid", int'(tx_command_valid), 1);
    chk("rd_tx_cmd", int'(tx_command), 1);
    chk("rd_alu_before_start", int'(alu_en), 0);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; #1;
    chk("rd_out1", int'(outstanding), 1);
    chk("rd_alu_no_next", int'(alu_en), 0);
    tx_data_next = 1; #1;
    chk("rd_alu_next", int'(alu_en), 1);
    op_done = 1;
    @(negedge clk);
    op_done = 0; tx_data_next = 0; #1;
    chk("rd_stage1", int'(stage), 1);
    chk("rd_alu_wait_data", int'(alu_en), 0);
    rx_started = 1; rx_data_valid = 1; rx_done = 1; #1;
    chk("rd_alu_data", int'(alu_en), 1);
    @(negedge clk);
    rx_done = 0; rx_started = 0; #1;
    chk("rd_out0", int'(outstanding), 0);
    op_done = 1; #1;
    chk("rd_done", int'(inst_done), 1);
    @(negedge clk); idle_inputs(); #1;
    chk("rd_stage0", int'(stage), 0);

    // Byte write in stage 2 of 3; reserve_tx covers only enabled stages.
    @(negedge clk);
    inst_valid = 1; num_stages = 3'd3; stage_write = 4'b1000; #1;
    chk("wr_rsv_masked", int'(reserve_tx), 0);
    stage_write = 4'b0100; #1;
    chk("wr_rsv_first", int'(reserve_tx), 1);
    op_done = 1;
    @(negedge clk); #1;
    chk("wr_stage1", int'(stage), 1);
    chk("wr_rsv_mid", int'(reserve_tx), 1);
    @(negedge clk);
    op_done = 0; #1;
    chk("wr_stage2", int'(stage), 2);
    chk("wr_tx_valid", int'(tx_command_valid), 1);
    chk("wr_tx_cmd", int'(tx_command), 3);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; #1;
    chk("wr_alu_gated", int'(alu_en), 0);
    tx_data_next = 1; #1;
    chk("wr_alu_next", int'(alu_en), 1);
    op_done = 1; #1;
    chk("wr_done", int'(inst_done), 1);
    @(negedge clk); idle_inputs();

    // PC stage held off while the prefetcher is busy.
    @(negedge clk);
    inst_valid = 1; num_stages = 3'd1; stage_pc = 4'b0001; stage_write = 4'b0001;
    wide = 1; prefetch_idle = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pc_block", int'(block_prefetch), 1);
      chk("pc_alu_held", int'(alu_en), 0);
      chk("pc_tx_held", int'(tx_command_valid), 0);
      @(negedge clk);
    end
    prefetch_idle = 1; #1;
    chk("pc_tx_valid", int'(tx_command_valid), 1);
    chk("pc_tx_cmd", int'(tx_command), 2);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; tx_data_next = 1; #1;
    chk("pc_alu_go", int'(alu_en), 1);
    op_done = 1;
    @(negedge clk); idle_inputs();

    // Back-to-back reads.
    @(negedge clk);
    inst_valid = 1; num_stages = 3'd2; stage_read = 4'b0011; #1;
    chk("two_tx_valid0", int'(tx_command_valid), 1);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; tx_data_next = 1; op_done = 1;
    @(negedge clk);
    op_done = 0; tx_data_next = 0; #1;
    chk("two_stage1", int'(stage), 1);
    chk("two_out1", int'(outstanding), 1);
`ifdef SEQ_PIPELINED_READ_EN
    chk("two_tx_valid1", int'(tx_command_valid), 1);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; #1;
    chk("two_out2", int'(outstanding), 2);
    tx_data_next = 1; op_done = 1; #1;
    chk("two_done", int'(inst_done), 1);
    @(negedge clk);
    op_done = 0; tx_data_next = 0; num_stages = 3'd1; stage_read = 4'b0001; #1;
    chk("third_held", int'(tx_command_valid), 0);
    rx_done = 1;
    @(negedge clk);
    rx_done = 0; #1;
    chk("third_out1", int'(outstanding), 1);
    chk("third_tx_valid", int'(tx_command_valid), 1);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; #1;
    chk("third_out2", int'(outstanding), 2);
    tx_data_next = 1; op_done = 1;
    @(negedge clk); idle_inputs(); rx_done = 1;
    @(negedge clk); rx_done = 1;
    @(negedge clk); rx_done = 0; #1;
    chk("drain_out0", int'(outstanding), 0);
`else
    chk("two_tx_held", int'(tx_command_valid), 0);
    rx_done = 1;
    @(negedge clk);
    rx_done = 0; #1;
    chk("two_out0", int'(outstanding), 0);
    chk("two_tx_valid1", int'(tx_command_valid), 1);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; #1;
    chk("two_out1b", int'(outstanding), 1);
    tx_data_next = 1; op_done = 1; #1;
    chk("two_done", int'(inst_done), 1);
    @(negedge clk); idle_inputs(); rx_done = 1;
    @(negedge clk); rx_done = 0; #1;
    chk("drain_out0", int'(outstanding), 0);
`endif

    // Unexpected reply, then reset in the middle of stage 2.
    @(negedge clk); rx_done = 1;
    @(negedge clk); rx_done = 0; #1;
    chk("perr_set", int'(protocol_error), 1);
    @(negedge clk); #1;
    chk("perr_sticky", int'(protocol_error), 1);
    inst_valid = 1; num_stages = 3'd3; stage_read = 4'b0001; #1;
    chk("abort_tx_valid", int'(tx_command_valid), 1);
    tx_command_started = 1;
    @(negedge clk);
    tx_command_started = 0; tx_data_next = 1; op_done = 1;
    @(negedge clk);
    tx_data_next = 0; op_done = 1;
    @(negedge clk);
    op_done = 0; #1;
    chk("abort_stage2", int'(stage), 2);
    chk("abort_out1", int'(outstanding), 1);
    reset = 1; op_done = 1; #1;
    chk("abort_no_done", int'(inst_done), 0);
    @(negedge clk);
    reset = 0; op_done = 0; inst_valid = 0; #1;
    chk("abort_stage0", int'(stage), 0);
    chk("abort_out0", int'(outstanding), 0);
    chk("abort_perr_clr", int'(protocol_error), 0);

    // Randomised instructions with reactive TX/ALU/RX responders.
    idle_inputs();
    need_new = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if (need_new) begin
        if ($urandom_range(0, 4) == 0) begin
          inst_valid = 0;
        end else begin
          inst_valid      = 1;
          num_stages      = 3'($urandom_range(0, 7));
          stage_read      = 4'($urandom) & 4'($urandom);
          stage_write     = 4'($urandom) & 4'($urandom);
          stage_wait_data = 4'($urandom) & 4'($urandom);
          stage_pc        = 4'($urandom) & 4'($urandom);
          wide            = 1'($urandom);
          use_cc          = 1'($urandom);
          cc              = 4'($urandom);
          flag_c = 1'($urandom); flag_v = 1'($urandom);
          flag_s = 1'($urandom); flag_z = 1'($urandom);
        end
      end
      prefetch_idle = ($urandom_range(0, 3) != 0);
      rx_started    = 1'($urandom);
      rx_data_valid = ($urandom_range(0, 2) == 0);
      tx_data_next  = 1'($urandom);
      tx_command_started = 0;
      op_done = 0;
      rx_done = (m_out > 0) && ($urandom_range(0, 3) == 0);
      begin
        exp_t e;
        e = model();
        tx_command_started = e.valid && ($urandom_range(0, 1) == 1);
        op_done            = e.alu && ($urandom_range(0, 1) == 1);
        e = model();
        if (e.done) n_inst++;
        need_new = e.done || reset || !inst_valid;
      end
    end
    @(negedge clk);
    reset = 0;
    idle_inputs();
    chk("rand_progress", int'(n_inst > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Generalised instruction sequencer for the 2-bit-serial CPU.
- Sits between the decoder and the ALU/TX/RX/prefetch interfaces.
- Evaluates the condition code and steps an instruction through 1..MAX_STAGES programmable stages instead of a fixed address/data pair.
- Issues TX commands per stage and tracks outstanding reads, so read replies can be consumed in order by later stages.

Parameters:
MAX_STAGES, 4, maximum stages per instruction (>=2)
MAX_OUTSTANDING, 2, maximum reads issued but not yet fully received (>=1)
TX_CMD_BITS, 2, width of TX command code

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
inst_valid  in  1  instruction present; decoder inputs stable until inst_done
inst_done  out  1  one-cycle pulse: instruction finished or skipped
num_stages  in  $clog2(MAX_STAGES)+1  stage count, 1..MAX_STAGES
stage_read  in  MAX_STAGES  stage s sends READ_16
stage_write  in  MAX_STAGES  stage s sends a write
stage_wait_data  in  MAX_STAGES  stage s consumes an RX reply
stage_pc  in  MAX_STAGES  stage s accesses PC
wide  in  1  write width select
use_cc  in  1  instruction is conditional
cc  in  4  condition code
flag_c, flag_v, flag_s, flag_z  in  1 each  ALU flags
stage  out  $clog2(MAX_STAGES)  current stage index
alu_en  out  1  ALU op_valid
op_done  in  1  ALU finished current stage
prefetch_idle  in  1  prefetcher idle
block_prefetch  out  1  hold off prefetch
reserve_tx  out  1  keep TX reserved for this instruction
tx_command_valid  out  1  command request
tx_command  out  TX_CMD_BITS  command code
tx_command_started  in  1  command accepted this cycle
tx_data_next  in  1  TX wants next payload symbol
rx_started  in  1  reply header started
rx_data_valid  in  1  reply payload symbol valid
rx_done  in  1  reply complete
outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
protocol_error  out  1  sticky: rx_done with outstanding==0

Behaviour:
- Reset: stage=0, command_active=0, outstanding=0, protocol_error=0. All outputs 0; inst_done=0 even if inst_valid is high.
- Condition code: cc[3] inverts the result; cc==4'b0000 means always.
  - cc[2:0] decode: 000 always; 001 z; 010 s; 011 always; 100 c; 101 v; 110 c&&!z; 111 v&&!z.
  - skip = inst_valid && use_cc && !cc_ok.
  - On skip: inst_done pulses combinationally, no command, alu_en=0, stage stays 0.
- Stage FSM: stage advances on op_done.
  - op_done with stage==num_stages-1 gives inst_done; stage returns to 0 next cycle.
  - command_active is set on tx_command_started and cleared on op_done.
- Per stage s, while executing:
  - send = stage_read[s] | stage_write[s]; read has priority.
  - tx_command = READ_16 if read, else WRITE_16 if wide, else WRITE_8.
  - cmd_wait = (stage_pc[s] && !prefetch_idle) || (stage_wait_data[s] && !rx_started) || (stage_read[s] && read_slots_full).
  - tx_command_valid = execute && send && !command_active && !cmd_wait.
  - alu_en = execute && !(stage_pc[s] && !prefetch_idle) && !(stage_wait_data[s] && !rx_data_valid) && !(send && !(command_active && tx_data_next)).
- block_prefetch = execute && stage_pc[s].
- reserve_tx = execute && |(stage_write masked to num_stages), held from the first cycle until inst_done.
- Outstanding counter:
  - +1 on tx_command_started with READ_16; -1 on rx_done.
  - Both in the same cycle: unchanged.
  - rx_done at 0: stays 0 and sets protocol_error.
  - read_slots_full = (outstanding == MAX_OUTSTANDING).
- Replies are consumed in order by stage_wait_data stages.
- num_stages of 0 is treated as 1; values above MAX_STAGES are clamped.
- Reset mid-instruction aborts it: no inst_done, and the counter clears.

Optional Feature:
- SEQ_PIPELINED_READ_EN defined: a read may issue while earlier reads are still outstanding, up to MAX_OUTSTANDING.
- Undefined: read_slots_full = (outstanding != 0), i.e. a single outstanding read; the outstanding width stays unchanged.

Decomposition:
- Shared package: TX command codes (READ_16, WRITE_16, WRITE_8), CC bit positions and encodings.
- Sub-module cc_eval: purely combinational condition evaluation, reusable elsewhere.

Test Plan:
- cc=4'b0001, use_cc=1, flag_z=0 -> inst_done same cycle, tx_command_valid/alu_en never high; cc=4'b1001 -> executes.
- num_stages=2, stage_read=01, stage_wait_data=10: READ_16 issued in stage 0, outstanding=1; stage 1 alu_en only with rx_data_valid; rx_done -> outstanding=0; inst_done after stage-1 op_done.
- num_stages=3, writes in stage 2, wide=0 -> tx_command=WRITE_8; reserve_tx high from first cycle to inst_done; alu_en gated by tx_data_next after start.
- stage_pc=1, prefetch_idle=0 for 5 cycles -> block_prefetch=1, alu_en=0 and no command until idle.
- SEQ_PIPELINED_READ_EN, MAX_OUTSTANDING=2: reads in stages 0 and 1 before any reply -> outstanding reaches 2; a third read is held until rx_done. Without the macro, the second read waits for rx_done.
- rx_done with outstanding=0 -> protocol_error=1 until reset; reset during stage 2 -> stage=0, outstanding=0, no inst_done.
